// File: rtl/stream_arb_pkg.sv
// Shared types and helpers for the EOT-aware stream arbiter.
// Tokens are {eot, data}: the eot flag sits directly above the payload.
package stream_arb_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StArb,
    StLocked,
    StFlush,
    StDone
  } arb_state_e;

  function automatic int unsigned tok_w(int unsigned data_w);
    return data_w + 1;
  endfunction

  function automatic int unsigned eot_idx(int unsigned data_w);
    return data_w;
  endfunction

  // Bit idx of the close token {1'b1, '0} for a given payload width.
  function automatic logic close_tok_bit(int unsigned data_w, int unsigned idx);
    return idx == eot_idx(data_w);
  endfunction

endpackage

// File: rtl/stream_rr_picker.sv
// Combinational round-robin pick: first requester strictly after ptr_i, wrapping.
module stream_rr_picker #(
  parameter int unsigned N    = 2,
  parameter int unsigned SelW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    req_i,
  input  logic [SelW-1:0] ptr_i,
  output logic [SelW-1:0] idx_o,
  output logic            valid_o
);

  logic [SelW-1:0] cand;

  // Scan from farthest to nearest so the nearest requester wins.
  always_comb begin
    idx_o   = '0;
    valid_o = 1'b0;
    cand    = '0;
    for (int k = int'(N); k >= 1; k--) begin
      cand = SelW'((int'(ptr_i) + k) % int'(N));
      if (req_i[cand]) begin
        idx_o   = cand;
        valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/stream_eot_arbiter.sv
// Round-robin merge of N_IN token streams into one, granting whole transactions
// (or MAX_BURST-word slices) and sequencing each run with an ap_ctrl handshake.
module stream_eot_arbiter
  import stream_arb_pkg::*;
#(
  parameter int unsigned N_IN      = 2,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned MERGE_EOT = 1,
  parameter int unsigned MAX_BURST = 0,
  localparam int unsigned TOK_W    = tok_w(DATA_W),
  localparam int unsigned SEL_W    = (N_IN > 1) ? $clog2(N_IN) : 1
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst,
  input  logic                  ap_start,
  output logic                  ap_done,
  output logic                  ap_idle,
  output logic                  ap_ready,
  input  logic [N_IN*TOK_W-1:0] in_s_dout,
  input  logic [N_IN-1:0]       in_s_empty_n,
  output logic [N_IN-1:0]       in_s_read,
  output logic [TOK_W-1:0]      out_s_din,
  input  logic                  out_s_full_n,
  output logic                  out_s_write,
  output logic [SEL_W-1:0]      out_src,
  output logic [N_IN-1:0]       closed_mask
);

  localparam int unsigned EOT_BIT = eot_idx(DATA_W);
  localparam int unsigned BURST_W = (MAX_BURST > 0) ? $clog2(MAX_BURST + 1) : 1;

  arb_state_e         state_q, state_d;
  logic [SEL_W-1:0]   ptr_q, ptr_d;
  logic [SEL_W-1:0]   grant_q, grant_d;
  logic [BURST_W-1:0] burst_q, burst_d;
  logic [N_IN-1:0]    closed_q, closed_d;

  logic [TOK_W-1:0] tok_arr [N_IN];
  logic [TOK_W-1:0] close_tok;
  logic [TOK_W-1:0] g_tok;
  logic             g_eot, g_avail, xfer;
  logic [SEL_W-1:0] pick_idx;
  logic             pick_valid;

  for (genvar i = 0; i < N_IN; i++) begin : g_unpack
    assign tok_arr[i] = in_s_dout[i*TOK_W +: TOK_W];
  end

  for (genvar b = 0; b < TOK_W; b++) begin : g_close
    assign close_tok[b] = close_tok_bit(DATA_W, b);
  end

  assign g_tok   = tok_arr[grant_q];
  assign g_eot   = g_tok[EOT_BIT];
  assign g_avail = in_s_empty_n[grant_q];

  stream_rr_picker #(
    .N    (N_IN),
    .SelW (SEL_W)
  ) u_picker (
    .req_i   (in_s_empty_n & ~closed_q),
    .ptr_i   (ptr_q),
    .idx_o   (pick_idx),
    .valid_o (pick_valid)
  );

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    grant_d     = grant_q;
    burst_d     = burst_q;
    closed_d    = closed_q;
    in_s_read   = '0;
    out_s_din   = '0;
    out_s_write = 1'b0;
    ap_done     = 1'b0;
    ap_ready    = 1'b0;
    ap_idle     = 1'b0;
    xfer        = 1'b0;
    unique case (state_q)
      StIdle: begin
        ap_idle = 1'b1;
        if (ap_start) begin
          closed_d = '0;
          state_d  = StArb;
        end
      end
      StArb: begin
        if (&closed_q) begin
          state_d = StFlush;
        end else if (pick_valid) begin
          grant_d = pick_idx;
          burst_d = '0;
          state_d = StLocked;
        end
      end
      StLocked: begin
        out_s_din = g_tok;
        if (g_eot && (MERGE_EOT != 0)) begin
          // Swallowed close token: consume it without touching the output.
          in_s_read[grant_q] = g_avail;
          if (g_avail) begin
            closed_d[grant_q] = 1'b1;
            ptr_d             = grant_q;
            state_d           = StArb;
          end
        end else begin
          xfer               = g_avail && out_s_full_n;
          in_s_read[grant_q] = xfer;
          out_s_write        = xfer;
          if (xfer && g_eot) begin
            closed_d[grant_q] = 1'b1;
            ptr_d             = grant_q;
            state_d           = StArb;
          end else if (xfer) begin
            burst_d = burst_q + 1'b1;
            if ((MAX_BURST > 0) && (burst_d == BURST_W'(MAX_BURST))) begin
              ptr_d   = grant_q;
              state_d = StArb;
            end
          end
        end
      end
      StFlush: begin
        if (MERGE_EOT != 0) begin
          out_s_din   = close_tok;
          out_s_write = out_s_full_n;
          if (out_s_full_n) state_d = StDone;
        end else begin
          state_d = StDone;
        end
      end
      StDone: begin
        ap_done  = 1'b1;
        ap_ready = 1'b1;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state_q  <= StIdle;
      ptr_q    <= SEL_W'(N_IN - 1);
      grant_q  <= '0;
      burst_q  <= '0;
      closed_q <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      grant_q  <= grant_d;
      burst_q  <= burst_d;
      closed_q <= closed_d;
    end
  end

  assign out_src     = grant_q;
  assign closed_mask = closed_q;

endmodule
